// File: rtl/tlb_mmu_if.sv
// rtl/tlb_mmu_if.sv - translation request/response bundle between the CPU address path and tlb_mmu
//
// Purpose: carries one virtual-address translation request and its registered response.
// Ports (as interface signals):
//   req_valid/req_ready   request handshake (ready driven by the TLB)
//   req_vaddr/req_write/req_asid  virtual address, store flag, current ASID
//   rsp_valid/rsp_ready   response handshake (valid driven by the TLB)
//   rsp_paddr/rsp_exc     physical address and exception code
//   rsp_*_ce              device selects for SRAM, flash, ROM, serial
interface tlb_mmu_if #(
  parameter int ASID_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_vaddr;
  logic              req_write;
  logic [ASID_W-1:0] req_asid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_paddr;
  logic [1:0]        rsp_exc;
  logic              rsp_sram_ce;
  logic              rsp_flash_ce;
  logic              rsp_rom_ce;
  logic              rsp_serial_ce;

  modport master (
    output req_valid, req_vaddr, req_write, req_asid, rsp_ready,
    input  req_ready, rsp_valid, rsp_paddr, rsp_exc,
           rsp_sram_ce, rsp_flash_ce, rsp_rom_ce, rsp_serial_ce
  );

  modport slave (
    input  req_valid, req_vaddr, req_write, req_asid, rsp_ready,
    output req_ready, rsp_valid, rsp_paddr, rsp_exc,
           rsp_sram_ce, rsp_flash_ce, rsp_rom_ce, rsp_serial_ce
  );
endinterface

// File: rtl/tlb_mmu.sv
// rtl/tlb_mmu.sv - joint dual-page TLB with segment decode and registered translation
//
// Purpose: translates virtual to physical addresses (kseg0/kseg1 unmapped, rest via TLB),
// reports refill/invalid/modified, and executes TLBWI/TLBWR/TLBP/TLBR with a Random counter.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   bus (tlb_mmu_if.slave)        translation request/response handshake
//   op_valid, op                  maintenance strobe and select (00 WI, 01 WR, 10 P, 11 R)
//   index_i, entryhi_i, entrylo0_i, entrylo1_i   CP0 register values
//   wired_i, wired_we             CP0 Wired value and its write pulse
//   random_o                      current Random value
//   probe_valid, probe_index      TLBP result pulse
//   tlbr_valid, tlbr_entry*       TLBR result pulse
module tlb_mmu #(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 8,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  tlb_mmu_if.slave         bus,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [31:0]      index_i,
  input  logic [31:0]      entryhi_i,
  input  logic [31:0]      entrylo0_i,
  input  logic [31:0]      entrylo1_i,
  input  logic [IDX_W-1:0] wired_i,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random_o,
  output logic             probe_valid,
  output logic [31:0]      probe_index,
  output logic             tlbr_valid,
  output logic [31:0]      tlbr_entryhi,
  output logic [31:0]      tlbr_entrylo0,
  output logic [31:0]      tlbr_entrylo1
);

  localparam logic [1:0] OP_TLBWI = 2'b00;
  localparam logic [1:0] OP_TLBWR = 2'b01;
  localparam logic [1:0] OP_TLBP  = 2'b10;
  localparam logic [1:0] OP_TLBR  = 2'b11;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_REFILL = 2'b01;
  localparam logic [1:0] EXC_INVAL  = 2'b10;
  localparam logic [1:0] EXC_MOD    = 2'b11;

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ENTRIES - 1);

  // Entry storage
  logic [18:0]       vpn2_q [ENTRIES];
  logic [ASID_W-1:0] asid_q [ENTRIES];
  logic              g_q    [ENTRIES];
  logic [19:0]       pfn0_q [ENTRIES];
  logic              d0_q   [ENTRIES];
  logic              v0_q   [ENTRIES];
  logic [19:0]       pfn1_q [ENTRIES];
  logic              d1_q   [ENTRIES];
  logic              v1_q   [ENTRIES];

  logic [IDX_W-1:0] random_q, random_d;

  logic        rsp_valid_q;
  logic [31:0] rsp_paddr_q, rsp_paddr_d;
  logic [1:0]  rsp_exc_q, rsp_exc_d;
  logic        sram_q, sram_d, flash_q, flash_d, rom_q, rom_d, serial_q, serial_d;

  logic        probe_valid_q;
  logic [31:0] probe_index_q;
  logic        tlbr_valid_q;
  logic [31:0] tlbr_hi_q, tlbr_lo0_q, tlbr_lo1_q;

  logic             req_fire;
  logic             op_write;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             lk_hit, pr_hit;
  logic [IDX_W-1:0] lk_idx, pr_idx;

  // Bits of the CP0 inputs that the TLB does not store
  logic unused_bits;
  assign unused_bits = ^{index_i[31:IDX_W], entryhi_i[12:ASID_W],
                         entrylo0_i[31:26], entrylo0_i[5:3],
                         entrylo1_i[31:26], entrylo1_i[5:3]};

  assign bus.req_ready = !rsp_valid_q | bus.rsp_ready;
  assign req_fire      = bus.req_valid & bus.req_ready;
  assign op_write      = op_valid & ((op == OP_TLBWI) | (op == OP_TLBWR));
  assign wr_idx        = (op == OP_TLBWR) ? random_q : index_i[IDX_W-1:0];
  assign rd_idx        = index_i[IDX_W-1:0];

  // Associative search for both the lookup and TLBP; scanning downward lets the
  // lowest matching index overwrite any higher one.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pr_hit = 1'b0;
    pr_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vpn2_q[i] == bus.req_vaddr[31:13] && (g_q[i] || asid_q[i] == bus.req_asid)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (vpn2_q[i] == entryhi_i[31:13] && (g_q[i] || asid_q[i] == entryhi_i[ASID_W-1:0])) begin
        pr_hit = 1'b1;
        pr_idx = IDX_W'(i);
      end
    end
  end

  // Segment decode and mapped result
  always_comb begin
    rsp_paddr_d = 32'h0;
    rsp_exc_d   = EXC_NONE;
    sram_d      = 1'b0;
    flash_d     = 1'b0;
    rom_d       = 1'b0;
    serial_d    = 1'b0;
    case (bus.req_vaddr[31:29])
      3'b100: begin
        rsp_paddr_d = {3'b000, bus.req_vaddr[28:0]};
        sram_d      = 1'b1;
      end
      3'b101: begin
        rsp_paddr_d = {3'b000, bus.req_vaddr[28:0]};
        flash_d     = (bus.req_vaddr[31:24] == 8'hBE);
        rom_d       = (bus.req_vaddr[31:12] == 20'hBFC00);
        serial_d    = ((bus.req_vaddr >= 32'hBFD003F8) && (bus.req_vaddr <= 32'hBFD003FC)) ||
                      (bus.req_vaddr == 32'hBFD0F010);
      end
      default: begin
        if (!lk_hit) begin
          rsp_exc_d = EXC_REFILL;
        end else if (bus.req_vaddr[12] ? !v1_q[lk_idx] : !v0_q[lk_idx]) begin
          rsp_exc_d = EXC_INVAL;
        end else if (bus.req_write && (bus.req_vaddr[12] ? !d1_q[lk_idx] : !d0_q[lk_idx])) begin
          rsp_exc_d = EXC_MOD;
        end else begin
          rsp_paddr_d = {(bus.req_vaddr[12] ? pfn1_q[lk_idx] : pfn0_q[lk_idx]),
                         bus.req_vaddr[11:0]};
          sram_d      = 1'b1;
        end
      end
    endcase
  end

  // Random wraps from Wired back to the top; a Wired at or beyond the top pins it there.
  always_comb begin
    if (wired_we || (wired_i >= MAX_IDX) || (random_q <= wired_i)) begin
      random_d = MAX_IDX;
    end else begin
      random_d = random_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        pfn0_q[i] <= '0;
        d0_q[i]   <= 1'b0;
        v0_q[i]   <= 1'b0;
        pfn1_q[i] <= '0;
        d1_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else if (op_write) begin
      vpn2_q[wr_idx] <= entryhi_i[31:13];
      asid_q[wr_idx] <= entryhi_i[ASID_W-1:0];
      g_q[wr_idx]    <= entrylo0_i[0] & entrylo1_i[0];
      pfn0_q[wr_idx] <= entrylo0_i[25:6];
      d0_q[wr_idx]   <= entrylo0_i[2];
      v0_q[wr_idx]   <= entrylo0_i[1];
      pfn1_q[wr_idx] <= entrylo1_i[25:6];
      d1_q[wr_idx]   <= entrylo1_i[2];
      v1_q[wr_idx]   <= entrylo1_i[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_q    <= MAX_IDX;
      rsp_valid_q <= 1'b0;
      rsp_paddr_q <= 32'h0;
      rsp_exc_q   <= EXC_NONE;
      sram_q      <= 1'b0;
      flash_q     <= 1'b0;
      rom_q       <= 1'b0;
      serial_q    <= 1'b0;
    end else begin
      random_q <= random_d;
      if (req_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_paddr_q <= rsp_paddr_d;
        rsp_exc_q   <= rsp_exc_d;
        sram_q      <= sram_d;
        flash_q     <= flash_d;
        rom_q       <= rom_d;
        serial_q    <= serial_d;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_valid_q <= 1'b0;
      probe_index_q <= 32'h0;
      tlbr_valid_q  <= 1'b0;
      tlbr_hi_q     <= 32'h0;
      tlbr_lo0_q    <= 32'h0;
      tlbr_lo1_q    <= 32'h0;
    end else begin
      probe_valid_q <= op_valid && (op == OP_TLBP);
      tlbr_valid_q  <= op_valid && (op == OP_TLBR);
      if (op_valid && (op == OP_TLBP)) begin
        probe_index_q <= pr_hit ? 32'(pr_idx) : 32'h8000_0000;
      end
      if (op_valid && (op == OP_TLBR)) begin
        tlbr_hi_q  <= {vpn2_q[rd_idx], 13'(asid_q[rd_idx])};
        tlbr_lo0_q <= {6'b0, pfn0_q[rd_idx], 3'b0, d0_q[rd_idx], v0_q[rd_idx], g_q[rd_idx]};
        tlbr_lo1_q <= {6'b0, pfn1_q[rd_idx], 3'b0, d1_q[rd_idx], v1_q[rd_idx], g_q[rd_idx]};
      end
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_paddr     = rsp_paddr_q;
  assign bus.rsp_exc       = rsp_exc_q;
  assign bus.rsp_sram_ce   = sram_q;
  assign bus.rsp_flash_ce  = flash_q;
  assign bus.rsp_rom_ce    = rom_q;
  assign bus.rsp_serial_ce = serial_q;

  assign random_o      = random_q;
  assign probe_valid   = probe_valid_q;
  assign probe_index   = probe_index_q;
  assign tlbr_valid    = tlbr_valid_q;
  assign tlbr_entryhi  = tlbr_hi_q;
  assign tlbr_entrylo0 = tlbr_lo0_q;
  assign tlbr_entrylo1 = tlbr_lo1_q;

endmodule

// File: tb/tb_tlb_mmu.sv
// tb/tb_tlb_mmu.sv - directed self-checking bench for tlb_mmu
//
// Purpose: drives directed translation and maintenance steps with hand-computed expectations.
// Ports: none (top-level bench).
module tb_tlb_mmu;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] index_i, entryhi_i, entrylo0_i, entrylo1_i;
  logic [3:0]  wired_i;
  logic        wired_we;
  logic [3:0]  random_o;
  logic        probe_valid;
  logic [31:0] probe_index;
  logic        tlbr_valid;
  logic [31:0] tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;

  int checks = 0;
  int errors = 0;

  tlb_mmu_if #(.ASID_W(8)) bus ();

  tlb_mmu #(.ENTRIES(16), .ASID_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .op_valid      (op_valid),
    .op            (op),
    .index_i       (index_i),
    .entryhi_i     (entryhi_i),
    .entrylo0_i    (entrylo0_i),
    .entrylo1_i    (entrylo1_i),
    .wired_i       (wired_i),
    .wired_we      (wired_we),
    .random_o      (random_o),
    .probe_valid   (probe_valid),
    .probe_index   (probe_index),
    .tlbr_valid    (tlbr_valid),
    .tlbr_entryhi  (tlbr_entryhi),
    .tlbr_entrylo0 (tlbr_entrylo0),
    .tlbr_entrylo1 (tlbr_entrylo1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] code, input logic [31:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
    op_valid   = 1'b1;
    op         = code;
    index_i    = idx;
    entryhi_i  = hi;
    entrylo0_i = lo0;
    entrylo1_i = lo1;
    tick();
    op_valid   = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] va, input logic wr, input logic [7:0] asid);
    bus.req_valid = 1'b1;
    bus.req_vaddr = va;
    bus.req_write = wr;
    bus.req_asid  = asid;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] pa, input logic [1:0] exc,
                         input logic [3:0] ces);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_paddr"}, bus.rsp_paddr, pa);
    chk({tag, "_exc"}, 32'(bus.rsp_exc), 32'(exc));
    chk({tag, "_ce"}, 32'({bus.rsp_sram_ce, bus.rsp_flash_ce, bus.rsp_rom_ce, bus.rsp_serial_ce}),
        32'(ces));
  endtask

  initial begin
    rst           = 1'b1;
    op_valid      = 1'b0;
    op            = 2'b00;
    index_i       = 32'h0;
    entryhi_i     = 32'h0;
    entrylo0_i    = 32'h0;
    entrylo1_i    = 32'h0;
    wired_i       = 4'd0;
    wired_we      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vaddr = 32'h0;
    bus.req_write = 1'b0;
    bus.req_asid  = 8'h0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_random", 32'(random_o), 32'd15);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_probe_valid", 32'(probe_valid), 32'd0);
    chk("rst_paddr", bus.rsp_paddr, 32'h0);
    rst = 1'b0;
    tick();

    do_op(2'b10, 32'h0, 32'h0040_0000, 32'h0, 32'h0);
    chk("probe_empty_valid", 32'(probe_valid), 32'd1);
    chk("probe_empty_idx", probe_index, 32'h8000_0000);
    tick();
    chk("probe_pulse_drop", 32'(probe_valid), 32'd0);

    // TLBWI to index 3 (upper index bits ignored) and lookups
    do_op(2'b00, 32'h0000_0023, 32'h0040_0005, 32'h0000_48C6, 32'h0);
    do_req(32'h0040_0ABC, 1'b0, 8'd5);
    chk_rsp("map_hit", 32'h0012_3ABC, 2'b00, 4'b1000);
    do_req(32'h0040_1ABC, 1'b0, 8'd5);
    chk_rsp("map_inval", 32'h0, 2'b10, 4'b0000);
    do_req(32'h0040_0ABC, 1'b0, 8'd6);
    chk_rsp("map_refill", 32'h0, 2'b01, 4'b0000);
    tick();
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);

    do_op(2'b10, 32'h0, 32'h0040_0005, 32'h0, 32'h0);
    chk("probe_hit_idx", probe_index, 32'd3);

    // Dirty check
    do_op(2'b00, 32'd3, 32'h0040_0005, 32'h0000_48C2, 32'h0);
    do_req(32'h0040_0ABC, 1'b1, 8'd5);
    chk_rsp("dirty_store", 32'h0, 2'b11, 4'b0000);
    do_req(32'h0040_0ABC, 1'b0, 8'd5);
    chk_rsp("dirty_load", 32'h0012_3ABC, 2'b00, 4'b1000);

    // Lookup and TLBWI on the same edge: lookup sees old contents
    op_valid      = 1'b1;
    op            = 2'b00;
    index_i       = 32'd3;
    entryhi_i     = 32'h0040_0005;
    entrylo0_i    = 32'h0000_48C6;
    entrylo1_i    = 32'h0;
    do_req(32'h0040_0ABC, 1'b1, 8'd5);
    op_valid      = 1'b0;
    chk_rsp("same_edge_old", 32'h0, 2'b11, 4'b0000);
    do_req(32'h0040_0ABC, 1'b1, 8'd5);
    chk_rsp("after_edge_new", 32'h0012_3ABC, 2'b00, 4'b1000);

    // Random with Wired = 4
    wired_i  = 4'd4;
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    chk("rand_after_we", 32'(random_o), 32'd15);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("rand_step", 32'(random_o), 32'(15 - k));
    end
    tick();
    chk("rand_wrap", 32'(random_o), 32'd15);
    repeat (6) tick();
    chk("rand_at9", 32'(random_o), 32'd9);
    do_op(2'b01, 32'd0, 32'h0ABC_E007, 32'h0001_2347, 32'h0004_5603);
    do_op(2'b11, 32'd9, 32'h0, 32'h0, 32'h0);
    chk("tlbr_valid", 32'(tlbr_valid), 32'd1);
    chk("tlbr_hi", tlbr_entryhi, 32'h0ABC_E007);
    chk("tlbr_lo0", tlbr_entrylo0, 32'h0001_2347);
    chk("tlbr_lo1", tlbr_entrylo1, 32'h0004_5603);
    tick();
    chk("tlbr_pulse_drop", 32'(tlbr_valid), 32'd0);

    // Backpressure
    bus.rsp_ready = 1'b0;
    do_req(32'h8000_1000, 1'b0, 8'd0);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_vaddr = 32'hBFC0_0010;
    repeat (2) begin
      tick();
      chk_rsp("bp_hold", 32'h0000_1000, 2'b00, 4'b1000);
      chk("bp_ready_held", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk_rsp("rom", 32'h1FC0_0010, 2'b00, 4'b0010);

    // Unmapped decode
    do_req(32'hBFD0_03F8, 1'b0, 8'd0);
    chk_rsp("serial", 32'h1FD0_03F8, 2'b00, 4'b0001);
    do_req(32'hBFD0_03FD, 1'b0, 8'd0);
    chk_rsp("serial_edge", 32'h1FD0_03FD, 2'b00, 4'b0000);
    do_req(32'hBFD0_F010, 1'b0, 8'd0);
    chk_rsp("serial_f010", 32'h1FD0_F010, 2'b00, 4'b0001);
    do_req(32'hBE00_0004, 1'b0, 8'd0);
    chk_rsp("flash", 32'h1E00_0004, 2'b00, 4'b0100);
    do_req(32'hA000_0100, 1'b0, 8'd0);
    chk_rsp("kseg1_none", 32'h0000_0100, 2'b00, 4'b0000);
    do_req(32'h8000_1000, 1'b1, 8'd0);
    chk_rsp("kseg0", 32'h0000_1000, 2'b00, 4'b1000);

    // Asynchronous reset with a pending response
    bus.rsp_ready = 1'b0;
    do_req(32'h8000_2000, 1'b0, 8'd0);
    chk("pend_valid", 32'(bus.rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst_random", 32'(random_o), 32'd15);
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    do_op(2'b10, 32'h0, 32'h0040_0005, 32'h0, 32'h0);
    chk("probe_after_rst", probe_index, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
